// File: rtl/par_align_pkg.sv
// Shared types and constants for the parallel word-alignment stage.
package par_align_pkg;

    localparam int         SLIP_CNT_W        = 4;
    localparam int         MATCH_CNT_W       = 8;
    localparam int         WAIT_CNT_W        = 4;
    localparam logic [7:0] TRAIN_PAT_DEFAULT = 8'hA5;

    // One-hot encoding keeps next-state decode shallow at par_clk rates.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_COMPARE   = 6'b000010,
        ST_SLIP      = 6'b000100,
        ST_SLIP_WAIT = 6'b001000,
        ST_LOCKED    = 6'b010000,
        ST_FAIL      = 6'b100000
    } align_state_t;

endpackage

// File: rtl/par_data_align.sv
// Trains the deserialised word boundary against a fixed pattern using bitslip
// pulses, then forwards registered data with lock / fail status.
module par_data_align
    import par_align_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] TRAIN_PAT = DATA_W'(TRAIN_PAT_DEFAULT),
    parameter int                MATCH_CNT = 16,
    parameter int                SLIP_WAIT = 4
) (
    input  logic                  clk_reset_n,
    input  logic                  par_clk,
    input  logic                  par_clk_rdy,
    input  logic                  align_start,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  bitslip,
    output logic                  aligned,
    output logic                  align_fail,
    output logic [SLIP_CNT_W-1:0] slip_count,
    output logic [DATA_W-1:0]     data_out
);

    localparam logic [SLIP_CNT_W-1:0]  LAST_SLIP  = SLIP_CNT_W'(DATA_W - 1);
    localparam logic [MATCH_CNT_W-1:0] MATCH_LAST = MATCH_CNT_W'(MATCH_CNT - 1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST  = WAIT_CNT_W'(SLIP_WAIT - 1);

    align_state_t            state;
    logic [DATA_W-1:0]       data_q;
    logic [MATCH_CNT_W-1:0]  match_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    pat_hit;

    assign pat_hit = (data_q == TRAIN_PAT);

    // Data path runs in every state; downstream qualifies it with aligned.
    always_ff @(posedge par_clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            data_q   <= '0;
            data_out <= '0;
        end else begin
            data_q   <= data_in;
            data_out <= data_q;
        end
    end

    always_ff @(posedge par_clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            state      <= ST_IDLE;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= '0;
            match_cnt  <= '0;
            wait_cnt   <= '0;
        end else if (!par_clk_rdy) begin
            // Losing the parallel clock overrides everything, including a match.
            state      <= ST_IDLE;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= '0;
            match_cnt  <= '0;
            wait_cnt   <= '0;
        end else begin
            bitslip <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state      <= ST_COMPARE;
                    match_cnt  <= '0;
                    slip_count <= '0;
                end
                ST_COMPARE: begin
                    if (pat_hit) begin
                        if (match_cnt != '1) begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                        if (match_cnt == MATCH_LAST) begin
                            state   <= ST_LOCKED;
                            aligned <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (slip_count == LAST_SLIP) begin
                            state      <= ST_FAIL;
                            align_fail <= 1'b1;
                        end else begin
                            state   <= ST_SLIP;
                            bitslip <= 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_count <= slip_count + 1'b1;
                    wait_cnt   <= '0;
                    state      <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    // Give the deserialiser and data_q time to settle on the new offset.
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_COMPARE;
                    end
                end
                ST_LOCKED: begin
                    if (align_start) begin
                        aligned    <= 1'b0;
                        slip_count <= '0;
                        match_cnt  <= '0;
                        state      <= ST_COMPARE;
                    end
                end
                ST_FAIL: begin
                    // Search resumes from the deserialiser's current offset.
                    if (align_start) begin
                        align_fail <= 1'b0;
                        slip_count <= '0;
                        match_cnt  <= '0;
                        state      <= ST_COMPARE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    aligned    <= 1'b0;
                    align_fail <= 1'b0;
                    slip_count <= '0;
                    match_cnt  <= '0;
                    wait_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_data_align.sv
// Randomised bench for par_data_align with a rotating deserialiser model and
// a counter-based behavioural reference checked every cycle.
module tb_par_data_align;

    localparam int         DATA_W    = 8;
    localparam logic [7:0] PAT       = 8'hA5;
    localparam int         MATCH_CNT = 16;
    localparam int         SLIP_WAIT = 4;

    logic       clk_reset_n;
    logic       par_clk;
    logic       par_clk_rdy;
    logic       align_start;
    logic [7:0] data_in;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic [3:0] slip_count;
    logic [7:0] data_out;

    par_data_align dut (
        .clk_reset_n (clk_reset_n),
        .par_clk     (par_clk),
        .par_clk_rdy (par_clk_rdy),
        .align_start (align_start),
        .data_in     (data_in),
        .bitslip     (bitslip),
        .aligned     (aligned),
        .align_fail  (align_fail),
        .slip_count  (slip_count),
        .data_out    (data_out)
    );

    initial par_clk = 1'b0;
    always #5 par_clk = ~par_clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] rol(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Deserialiser: word rotates left once per observed bitslip pulse.
    logic [7:0] src_word = PAT;
    logic [7:0] glitch   = 8'h00;
    bit         rot_en   = 1'b1;
    int         rot      = 0;
    int         rot_base = 0;

    always @(posedge par_clk) begin
        if (clk_reset_n && rot_en && bitslip === 1'b1) rot++;
    end

    always @(negedge par_clk) begin
        #2;
        data_in = rol(src_word, rot - rot_base) ^ glitch;
    end

    // Reference: counters describe progress instead of named states.
    bit         m_active, m_locked, m_failed, m_bs;
    int         m_run, m_hold, m_slips;
    logic [7:0] m_q, m_out, cmp_word;

    always @(posedge par_clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            m_active = 0; m_locked = 0; m_failed = 0; m_bs = 0;
            m_run = 0; m_hold = 0; m_slips = 0;
            m_q = 8'h00; m_out = 8'h00;
        end else begin
            cmp_word = m_q;
            m_out    = m_q;
            m_q      = data_in;
            m_bs     = 0;
            if (!par_clk_rdy) begin
                m_active = 0; m_locked = 0; m_failed = 0;
                m_run = 0; m_hold = 0; m_slips = 0;
            end else if (!m_active) begin
                m_active = 1; m_run = 0; m_slips = 0; m_hold = 0;
            end else if (m_locked) begin
                if (align_start) begin m_locked = 0; m_run = 0; m_slips = 0; end
            end else if (m_failed) begin
                if (align_start) begin m_failed = 0; m_slips = 0; end
            end else if (m_hold > 0) begin
                if (m_hold == SLIP_WAIT + 1) m_slips++;
                m_hold--;
            end else if (cmp_word == PAT) begin
                m_run = (m_run < 255) ? m_run + 1 : 255;
                if (m_run == MATCH_CNT) m_locked = 1;
            end else begin
                m_run = 0;
                if (m_slips == DATA_W - 1) m_failed = 1;
                else begin m_hold = SLIP_WAIT + 1; m_bs = 1; end
            end
        end
    end

    always @(negedge par_clk) begin
        if (chk_en) begin
            check("bitslip",    32'(bitslip),    32'(m_bs));
            check("aligned",    32'(aligned),    32'(m_locked));
            check("align_fail", 32'(align_fail), 32'(m_failed));
            check("slip_count", 32'(slip_count), 32'(m_slips));
            check("data_out",   32'(data_out),   32'(m_out));
        end
    end

    // Drop rdy, load a new source word, then raise rdy on a negedge.
    task automatic restart(input logic [7:0] w, input bit en);
        @(negedge par_clk);
        par_clk_rdy = 1'b0;
        @(negedge par_clk);
        src_word = w; rot_en = en; rot_base = rot; glitch = 8'h00;
        @(negedge par_clk);
        par_clk_rdy = 1'b1;
    endtask

    // sel 0 waits for aligned, sel 1 for align_fail; k counts negedges since rdy rose.
    task automatic run_until(input int sel, input int bound, input bit inject, input int k0,
                             output int k, output int npulse, output int mingap, output int wide);
        int  last;
        bit  prev;
        bit  injected;
        k = k0; npulse = 0; mingap = 1000; wide = 0; last = -1; prev = 0; injected = 0;
        while (((sel == 0) ? !aligned : !align_fail) && k < bound) begin
            @(negedge par_clk);
            k++;
            align_start = 1'b0;
            if (inject && !injected && last >= 0 && k == last + 1) begin
                align_start = 1'b1;
                injected = 1;
            end
            if (bitslip) begin
                if (prev) wide++;
                else begin
                    npulse++;
                    if (last >= 0 && k - last < mingap) mingap = k - last;
                    last = k;
                end
            end
            prev = bitslip;
        end
        align_start = 1'b0;
    endtask

    initial begin
        int  k, np, mg, wd;
        bit  seen;
        clk_reset_n = 1'b0;
        par_clk_rdy = 1'b0;
        align_start = 1'b0;
        #1;
        chk_en = 1'b1;
        repeat (3) @(negedge par_clk);
        check("rst_bitslip",    32'(bitslip),    0);
        check("rst_aligned",    32'(aligned),    0);
        check("rst_align_fail", 32'(align_fail), 0);
        check("rst_slip_count", 32'(slip_count), 0);
        check("rst_data_out",   32'(data_out),   0);
        clk_reset_n = 1'b1;

        // Already aligned.
        restart(PAT, 1'b1);
        run_until(0, 60, 1'b0, 0, k, np, mg, wd);
        check("start_lock_edge", k, 17);
        check("start_pulses", np, 0);
        check("start_slip_count", 32'(slip_count), 0);
        check("start_data_out", 32'(data_out), 32'hA5);
        $display("aligned_at_start: lock seen after %0d edges", k);
        src_word = 8'h3C;
        repeat (20) @(negedge par_clk) src_word = 8'($urandom);

        // Clock loss while locked, then recovery.
        par_clk_rdy = 1'b0;
        @(negedge par_clk);
        check("loss_aligned", 32'(aligned), 0);
        restart(PAT, 1'b1);
        run_until(0, 60, 1'b0, 0, k, np, mg, wd);
        check("relock_edge", k, 17);
        $display("clock_loss: relock after %0d edges", k);

        // align_start together with rdy low while locked.
        par_clk_rdy = 1'b0; align_start = 1'b1;
        @(negedge par_clk);
        align_start = 1'b0;
        check("prio_aligned", 32'(aligned), 0);
        repeat (2) @(negedge par_clk);

        // Offset 3, with an ignored align_start during the first wait.
        restart(8'hB4, 1'b1);
        run_until(0, 300, 1'b1, 0, k, np, mg, wd);
        check("off3_pulses", np, 3);
        check("off3_slip_count", 32'(slip_count), 3);
        check("off3_align_fail", 32'(align_fail), 0);
        check("off3_gap_ge_6", 32'(mg >= SLIP_WAIT + 2), 1);
        check("off3_wide_pulses", wd, 0);
        check("off3_lock_edge", k, 35);
        $display("offset3: %0d pulses, min gap %0d, lock at %0d", np, mg, k);

        // No training pattern at any offset.
        restart(8'h00, 1'b1);
        run_until(1, 300, 1'b0, 0, k, np, mg, wd);
        check("nopat_pulses", np, 7);
        check("nopat_slip_count", 32'(slip_count), 7);
        check("nopat_aligned", 32'(aligned), 0);
        repeat (10) @(negedge par_clk);
        check("nopat_hold_fail", 32'(align_fail), 1);
        align_start = 1'b1;
        @(negedge par_clk);
        align_start = 1'b0;
        check("restart_fail_clr", 32'(align_fail), 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge par_clk);
            if (bitslip) seen = 1;
        end
        check("restart_slip_seen", 32'(seen), 1);
        $display("no_pattern: fail after %0d pulses, retry slip=%0d", np, seen);

        // Broken run: 10 matches, a corrupted word, then a fresh run of 16.
        restart(PAT, 1'b0);
        k = 0;
        repeat (10) begin @(negedge par_clk); k++; end
        glitch = 8'hFF;
        @(negedge par_clk); k++;
        glitch = 8'h00;
        run_until(0, 100, 1'b0, k, k, np, mg, wd);
        check("broken_pulses", np, 1);
        check("broken_lock_edge", k, 33);
        $display("broken_run: lock at %0d with %0d pulses", k, np);

        // Random traffic.
        rot_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge par_clk);
            if (i % 100 == 0) src_word = ($urandom % 2) ? rol(PAT, $urandom % 8) : 8'($urandom);
            glitch      = ($urandom % 40 == 0) ? 8'($urandom) : 8'h00;
            par_clk_rdy = ($urandom % 80 != 0);
            align_start = ($urandom % 25 == 0);
        end
        align_start = 1'b0;
        $display("random: 800 cycles applied");

        // Asynchronous reset while bitslip is high.
        restart(8'hB4, 1'b1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge par_clk);
            if (bitslip) seen = 1;
        end
        check("arst_slip_seen", 32'(seen), 1);
        #1 clk_reset_n = 1'b0;
        #1 check("arst_bitslip", 32'(bitslip), 0);
        @(negedge par_clk);
        clk_reset_n = 1'b1;
        repeat (3) @(negedge par_clk);
        $display("async_reset: bitslip=%0d after reset", bitslip);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
